// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU opcode encodings, sequencer states and mul/div
//               operation select.
// Revision    : 1.0 - multi-cycle ALU successor
// ============================================================================
`default_nettype none

package alu_pkg;

   // 4-bit alu_control encoding, kept compatible with the single-cycle ALU
   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_OR   = 4'd1;
   localparam logic [3:0] ALU_ADD  = 4'd2;
   localparam logic [3:0] ALU_MULU = 4'd3;
   localparam logic [3:0] ALU_DIVU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SUB  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_NOR  = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } alu_state_t;

   typedef enum logic {
      MD_MUL = 1'b0,
      MD_DIV = 1'b1
   } md_op_t;

endpackage

`default_nettype wire

// File: rtl/seq_muldiv_core.sv
// ============================================================================
// Module      : seq_muldiv_core
// Description : Iterative unsigned shift-add multiplier / restoring divider
//               sharing one 2*WIDTH accumulator and one add/subtract step.
// Revision    : 1.0 - multi-cycle ALU successor
// ============================================================================
`default_nettype none

module seq_muldiv_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  md_op_t           op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi
);

   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [WIDTH-1:0]   r_opnd;
   logic [CNT_W-1:0]   r_cnt;
   md_op_t             r_op;
   logic [WIDTH:0]     w_x;
   logic [WIDTH:0]     w_y;
   logic [WIDTH:0]     w_sum;
   logic               w_sub;

   // Multiply adds into the high half; divide trial-subtracts from the
   // left-shifted remainder, so the shared adder is WIDTH+1 bits.
   always_comb begin
      w_sub      = (r_op == MD_DIV);
      w_x        = w_sub ? r_acc[2*WIDTH-1:WIDTH-1] : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
      w_y        = {1'b0, r_opnd};
      w_sum      = w_x + (w_sub ? ~w_y : w_y) + {{WIDTH{1'b0}}, w_sub};
      w_acc_next = r_acc;
      if (!w_sub) begin
         if (r_acc[0]) w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
         else          w_acc_next = {1'b0, r_acc[2*WIDTH-1:1]};
      end else begin
         if (!w_sum[WIDTH]) w_acc_next = {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
         else               w_acc_next = {r_acc[2*WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc  <= '0;
         r_opnd <= '0;
         r_cnt  <= '0;
         r_op   <= MD_MUL;
      end else if (start) begin
         r_acc  <= {{WIDTH{1'b0}}, a};
         r_opnd <= b;
         r_op   <= op;
         r_cnt  <= CNT_W'(WIDTH);
      end else if (r_cnt != '0) begin
         r_acc  <= w_acc_next;
         r_cnt  <= r_cnt - CNT_W'(1);
      end
   end

   // Result is taken from the final iteration's next-state value
   assign done   = (r_cnt == CNT_W'(1));
   assign res_lo = w_acc_next[WIDTH-1:0];
   assign res_hi = w_acc_next[2*WIDTH-1:WIDTH];

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module      : seq_alu
// Description : Multi-cycle execute-stage ALU with valid/ready operand
//               handshake, registered results and iterative MULU/DIVU.
// Revision    : 1.0 - multi-cycle ALU successor
// ============================================================================
`default_nettype none

module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] alu_out,
   output logic [WIDTH-1:0] hi_out,
   output logic             zero,
   output logic             lsb,
   output logic             div_by_zero
);

   alu_state_t       r_state;
   alu_state_t       w_state_next;
   logic [WIDTH-1:0] w_alu_res;
   logic [WIDTH-1:0] w_res_lo;
   logic [WIDTH-1:0] w_res_hi;
   logic [WIDTH-1:0] w_core_lo;
   logic [WIDTH-1:0] w_core_hi;
   logic             w_core_done;
   logic             w_start;
   logic             w_load;
   logic             w_dbz;
   md_op_t           w_md_op;
   logic [WIDTH-1:0] r_alu_out;
   logic [WIDTH-1:0] r_hi_out;
   logic             r_out_valid;
   logic             r_dbz;

   always_comb begin
      case (alu_control)
         ALU_AND:  w_alu_res = a & b;
         ALU_OR:   w_alu_res = a | b;
         ALU_ADD:  w_alu_res = a + b;
         ALU_SUB:  w_alu_res = a - b;
         ALU_XOR:  w_alu_res = a ^ b;
         ALU_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         ALU_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_NOR:  w_alu_res = ~(a | b);
         default:  w_alu_res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_md_op      = MD_MUL;
      w_load       = 1'b0;
      w_dbz        = 1'b0;
      w_res_lo     = '0;
      w_res_hi     = '0;
      case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               if (alu_control == ALU_MULU) begin
                  w_start      = 1'b1;
                  w_state_next = ST_MUL;
               end else if (alu_control == ALU_DIVU && b == '0) begin
                  // Divide by zero resolves immediately without iterating
                  w_load   = 1'b1;
                  w_dbz    = 1'b1;
                  w_res_lo = '1;
                  w_res_hi = a;
               end else if (alu_control == ALU_DIVU) begin
                  w_start      = 1'b1;
                  w_md_op      = MD_DIV;
                  w_state_next = ST_DIV;
               end else begin
                  w_load   = 1'b1;
                  w_res_lo = w_alu_res;
               end
            end
         end
         ST_MUL, ST_DIV: begin
            if (w_core_done) begin
               w_load       = 1'b1;
               w_res_lo     = w_core_lo;
               w_res_hi     = w_core_hi;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_out   <= '0;
         r_hi_out    <= '0;
         r_out_valid <= 1'b0;
         r_dbz       <= 1'b0;
      end else begin
         r_out_valid <= w_load;
         r_dbz       <= w_dbz;
         if (w_load) begin
            r_alu_out <= w_res_lo;
            r_hi_out  <= w_res_hi;
         end
      end
   end

   seq_muldiv_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .clk    (clk),
      .rst    (rst),
      .start  (w_start),
      .op     (w_md_op),
      .a      (a),
      .b      (b),
      .done   (w_core_done),
      .res_lo (w_core_lo),
      .res_hi (w_core_hi)
   );

   assign in_ready    = (r_state == ST_IDLE);
   assign out_valid   = r_out_valid;
   assign alu_out     = r_alu_out;
   assign hi_out      = r_hi_out;
   assign zero        = (r_alu_out == '0);
   assign lsb         = r_alu_out[0];
   assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module      : tb_seq_alu
// Description : Scoreboard bench for seq_alu at WIDTH=32 and WIDTH=8.
// Revision    : 1.0 - multi-cycle ALU successor
// ============================================================================
`default_nettype none

module tb_seq_alu;

   typedef struct {
      int          id;
      bit          w8;
      logic [63:0] lo;
      logic [63:0] hi;
      logic        dbz;
      int          k;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        vld32, vld8;
   logic [3:0]  ctl32, ctl8;
   logic [31:0] a32, b32;
   logic [7:0]  a8, b8;
   logic        in_ready32, out_valid32, zero32, lsb32, dbz32;
   logic        in_ready8, out_valid8, zero8, lsb8, dbz8;
   logic [31:0] alu_out32, hi_out32;
   logic [7:0]  alu_out8, hi_out8;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   next_id  = 0;
   exp_t sb32[$];
   exp_t sb8[$];
   exp_t e32, e8;

   seq_alu #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(vld32), .in_ready(in_ready32),
      .alu_control(ctl32), .a(a32), .b(b32), .out_valid(out_valid32),
      .alu_out(alu_out32), .hi_out(hi_out32), .zero(zero32), .lsb(lsb32),
      .div_by_zero(dbz32)
   );

   seq_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(vld8), .in_ready(in_ready8),
      .alu_control(ctl8), .a(a8), .b(b8), .out_valid(out_valid8),
      .alu_out(alu_out8), .hi_out(hi_out8), .zero(zero8), .lsb(lsb8),
      .div_by_zero(dbz8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
   endtask

   // Reference behaviour computed in wide arithmetic, masked to w bits
   function automatic exp_t model(input int w, input logic [3:0] op,
                                  input logic [31:0] av, input logic [31:0] bv);
      exp_t        e;
      logic [63:0] m, x, y, p;
      longint      sx, sy;
      m = (64'd1 << w) - 64'd1;
      x = {32'd0, av} & m;
      y = {32'd0, bv} & m;
      e.id = 0; e.w8 = 0; e.k = 0; e.lat = 1;
      e.lo = '0; e.hi = '0; e.dbz = 1'b0;
      sx = longint'(x);
      sy = longint'(y);
      if (x[w-1]) sx = sx - longint'(64'd1 << w);
      if (y[w-1]) sy = sy - longint'(64'd1 << w);
      case (op)
         4'd0:  e.lo = x & y;
         4'd1:  e.lo = x | y;
         4'd2:  e.lo = x + y;
         4'd3:  begin p = x * y; e.lo = p; e.hi = (p >> w) & m; e.lat = w + 1; end
         4'd4:  begin
            if (y == 0) begin e.lo = m; e.hi = x; e.dbz = 1'b1; end
            else begin e.lo = x / y; e.hi = x % y; e.lat = w + 1; end
         end
         4'd5:  e.lo = x ^ y;
         4'd6:  e.lo = x - y;
         4'd7:  e.lo = (x < y) ? 64'd1 : 64'd0;
         4'd8:  e.lo = (sx < sy) ? 64'd1 : 64'd0;
         4'd10: e.lo = ~(x | y);
         default: e.lo = '0;
      endcase
      e.lo = e.lo & m;
      return e;
   endfunction

   task automatic compare_out(input exp_t e, input logic [63:0] lo, input logic [63:0] hi,
                              input logic z, input logic l, input logic d);
      string p;
      p = $sformatf("%s#%0d", e.w8 ? "w8" : "w32", e.id);
      check({p, ".alu_out"}, lo, e.lo);
      check({p, ".hi_out"}, hi, e.hi);
      check({p, ".zero"}, 64'(z), 64'(e.lo == 0));
      check({p, ".lsb"}, 64'(l), 64'(e.lo[0]));
      check({p, ".div_by_zero"}, 64'(d), 64'(e.dbz));
      check({p, ".latency"}, 64'(cyc + 1 - e.k), 64'(e.lat));
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid32) begin
         if (sb32.size() == 0) check("unexpected_valid32", 64'(out_valid32), 64'd0);
         else begin
            e32 = sb32.pop_front();
            compare_out(e32, 64'(alu_out32), 64'(hi_out32), zero32, lsb32, dbz32);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && out_valid8) begin
         if (sb8.size() == 0) check("unexpected_valid8", 64'(out_valid8), 64'd0);
         else begin
            e8 = sb8.pop_front();
            compare_out(e8, 64'(alu_out8), 64'(hi_out8), zero8, lsb8, dbz8);
         end
      end
   end

   // Called at a negedge; the op is accepted at the following posedge
   task automatic issue(input bit w8, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv);
      exp_t e;
      e    = model(w8 ? 8 : 32, op, av, bv);
      e.id = next_id;
      e.w8 = w8;
      e.k  = cyc + 1;
      next_id++;
      if (w8) begin
         check($sformatf("w8#%0d.in_ready", e.id), 64'(in_ready8), 64'd1);
         a8 = av[7:0]; b8 = bv[7:0]; ctl8 = op; vld8 = 1'b1;
         sb8.push_back(e);
      end else begin
         check($sformatf("w32#%0d.in_ready", e.id), 64'(in_ready32), 64'd1);
         a32 = av; b32 = bv; ctl32 = op; vld32 = 1'b1;
         sb32.push_back(e);
      end
      @(negedge clk);
      vld8  = 1'b0;
      vld32 = 1'b0;
   endtask

   task automatic wait_drain(input int max_cycles);
      int n;
      n = 0;
      while ((sb32.size() != 0 || sb8.size() != 0) && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      if (sb32.size() != 0 || sb8.size() != 0) begin
         check("drain_timeout", 64'(sb32.size() + sb8.size()), 64'd0);
         sb32.delete();
         sb8.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ops [11];
      logic [3:0] op;
      logic [31:0] ra, rb;
      ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd9};
      rst = 1'b1; vld32 = 1'b0; vld8 = 1'b0;
      ctl32 = '0; ctl8 = '0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
      repeat (3) @(negedge clk);
      check("rst.alu_out", 64'(alu_out32), 64'd0);
      check("rst.hi_out", 64'(hi_out32), 64'd0);
      check("rst.out_valid", 64'(out_valid32), 64'd0);
      check("rst.zero", 64'(zero32), 64'd1);
      check("rst.lsb", 64'(lsb32), 64'd0);
      check("rst.div_by_zero", 64'(dbz32), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst.in_ready", 64'(in_ready32), 64'd1);

      // Back-to-back single-cycle ops
      issue(0, 4'd2, 32'hFFFF_FFFF, 32'd1);
      issue(0, 4'd6, 32'd5, 32'd7);
      issue(0, 4'd8, 32'hFFFF_FFFF, 32'd1);
      issue(0, 4'd7, 32'hFFFF_FFFF, 32'd1);
      issue(0, 4'd10, 32'd0, 32'd0);
      issue(0, 4'd5, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
      issue(0, 4'd0, 32'hF0F0_1234, 32'h0FF0_FF00);
      issue(0, 4'd1, 32'h8000_0000, 32'h0000_0001);
      issue(0, 4'd9, 32'h1234_5678, 32'h9ABC_DEF0);
      issue(0, 4'd8, 32'd3, 32'h8000_0000);
      wait_drain(5);

      // MULU: busy for WIDTH cycles, ignores in_valid and operand changes
      issue(0, 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int i = 0; i < 32; i++) begin
         check($sformatf("mul_busy.in_ready[%0d]", i), 64'(in_ready32), 64'd0);
         if (i == 10) begin vld32 = 1'b1; ctl32 = 4'd2; a32 = $urandom; b32 = $urandom; end
         if (i == 11) vld32 = 1'b0;
         @(negedge clk);
      end
      check("mul_done.in_ready", 64'(in_ready32), 64'd1);
      wait_drain(5);

      issue(0, 4'd4, 32'd100, 32'd7);
      wait_drain(40);
      issue(0, 4'd4, 32'd5, 32'd0);
      @(negedge clk);
      check("dbz_pulse.div_by_zero", 64'(dbz32), 64'd0);
      check("dbz_pulse.out_valid", 64'(out_valid32), 64'd0);

      for (int i = 0; i < 8; i++) begin
         op = ops[$urandom_range(0, 10)];
         ra = $urandom;
         rb = (i == 3) ? 32'd0 : ((op == 4'd4) ? ($urandom >> $urandom_range(0, 28)) : $urandom);
         issue(0, op, ra, rb);
         wait_drain(40);
      end

      // Reset during MULU aborts it without a result pulse
      issue(0, 4'd2, 32'd20, 32'd22);
      wait_drain(5);
      issue(0, 4'd3, 32'd123456, 32'd789);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort.alu_out", 64'(alu_out32), 64'd0);
      check("abort.hi_out", 64'(hi_out32), 64'd0);
      check("abort.out_valid", 64'(out_valid32), 64'd0);
      check("abort.zero", 64'(zero32), 64'd1);
      sb32.delete();
      @(negedge clk);
      rst = 1'b0;
      check("abort.in_ready", 64'(in_ready32), 64'd1);
      repeat (40) @(negedge clk);
      issue(0, 4'd2, 32'd2, 32'd3);
      wait_drain(5);

      // Narrow instance
      issue(1, 4'd3, 32'hFF, 32'h02);
      wait_drain(20);
      issue(1, 4'd4, 32'd200, 32'd7);
      wait_drain(20);
      issue(1, 4'd8, 32'h80, 32'h01);
      issue(1, 4'd2, 32'hF0, 32'h20);
      issue(1, 4'd4, 32'd9, 32'd0);
      wait_drain(5);
      for (int i = 0; i < 6; i++) begin
         op = ops[$urandom_range(0, 10)];
         issue(1, op, $urandom, $urandom_range(0, 255));
         wait_drain(20);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
